proc_control_fsm: RTL and testbench
===================================

Name: proc_control_fsm

Overview:
Instruction-sequencing control unit for the 16-bit six-instruction processor.
- Latches each instruction word from DIN into an internal IR.
- Steps a T0–T3 state machine.
- Each cycle, drives the bus-source select consumed by the Mux_2_to_1-based bus multiplexer chain, plus the register, accumulator and ALU enables.
- Sits directly upstream of the bus mux and datapath registers.

Parameters:
- NREG, 8, number of general registers (R0..R7); fixes Rx/Ry field width at 3.
- DW, 16, instruction and data width.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  start a new instruction; sampled only in T0.
- DIN  input  DW  instruction word (T0) or immediate (mvi, T1).
- GNZ  input  1  datapath flag: G register != 0.
- Sel  output  4  bus-source code to the mux chain (see package).
- Rin  output  NREG  one-hot register write enables.
- Ain  output  1  load A register.
- Gin  output  1  load G register.
- AluOp  output  2  00 ADD, 01 SUB, 10 AND.
- IRin  output  1  IR load strobe (observability).
- Done  output  1  instruction complete, one cycle.
- Illegal  output  1  sticky illegal-opcode flag (feature only; tied 0 otherwise).

Behaviour:
- Instruction format: IR[15:13] opcode, IR[12:10] Rx, IR[9:7] Ry, IR[6:0] ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 mvnz, 110/111 illegal.
- States: T0, T1, T2, T3. Registered state and IR; all outputs combinational from state, IR, DIN and GNZ.
- Default output values unless listed: Sel = NONE(15), Rin = 0, Ain = Gin = Done = IRin = 0, AluOp = 00.
- T0:
  - If Run: IRin = 1; IR <= DIN at the edge; next state T1.
  - Else stay in T0.
- T1:
  - mv: Sel = Ry, Rin[Rx] = 1, Done = 1 → T0.
  - mvi: Sel = DIN(9), Rin[Rx] = 1, Done = 1 → T0. The immediate must be on DIN during T1.
  - add/sub/and: Sel = Rx, Ain = 1 → T2.
  - mvnz: if GNZ then Sel = Ry and Rin[Rx] = 1; Done = 1 regardless → T0.
  - Illegal opcode: Done = 1 → T0 (NOP).
- T2 (add/sub/and): Sel = Ry, Gin = 1, AluOp per opcode → T3.
- T3: Sel = G(8), Rin[Rx] = 1, Done = 1 → T0.
- Latency, counted from the T0 cycle with Run high:
  - mv/mvi/mvnz/illegal: Done in cycle 2.
  - ALU ops: Done in cycle 4.
- Run in T1–T3 is ignored. A held Run starts a new instruction on every T0 (back-to-back).
- Rx = Ry is legal, e.g. add R2,R2 doubles R2.
- Reset: outputs forced to defaults during any cycle Reset is high. Next state T0, IR = 0, Illegal = 0. Mid-instruction reset aborts the instruction with no further enables.
- At most one Rin bit is high in any cycle. Ain, Gin and any Rin bit are never high in the same cycle.

Optional Feature:
- Macro PROC_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in T1 sets Illegal = 1 (sticky) and Done = 0.
  - The FSM enters state HALT: all outputs default, Run ignored, exit only via Reset.
- Undefined:
  - Illegal opcodes execute as a 2-cycle NOP with Done.
  - Illegal output tied 0; no HALT state.

Decomposition:
- Package proc_pkg:
  - opcode_t enum.
  - state_t enum (T0, T1, T2, T3, HALT).
  - Sel codes: R0..R7 = 0..7, SEL_G = 8, SEL_DIN = 9, SEL_NONE = 15.
  - AluOp constants.
  - Field-slice localparams.
- One sub-module, reg_decoder_3to8: 3-bit index plus enable → one-hot Rin.

Test Plan:
- Reset then Run = 1, DIN = 16'h2800, then DIN = 16'h00AA in T1 → T1: Sel = 9, Rin = 8'b00000100, Done = 1; T0 returns the next cycle.
- DIN = 16'h0580 (mv R1,R3) → T1: Sel = 3, Rin = 8'b00000010, Done = 1.
- DIN = 16'h6E00 (sub R3,R4) → T1 Sel = 3, Ain = 1; T2 Sel = 4, Gin = 1, AluOp = 01; T3 Sel = 8, Rin = 8'b00001000, Done = 1.
- DIN = 16'hB700 (mvnz R5,R6):
  - GNZ = 0 → T1: Rin = 0, Done = 1.
  - Repeat with GNZ = 1 → Sel = 6, Rin = 8'b00100000.
- DIN = 16'h4080 (add) with Reset asserted in T2 → next cycle T0, all outputs default, no Rin pulse ever; a new Run is accepted afterwards.
- DIN = 16'hE000:
  - Macro off → Done in T1, Rin = 0.
  - Macro on → Illegal = 1, Done = 0, further Run ignored until Reset clears Illegal.

Source files
------------

// File: rtl/proc_control_fsm_pkg.sv
// Shared types and constants for the instruction-sequencing control unit.
// Optional feature macro: PROC_ILLEGAL_TRAP_EN (illegal opcode traps to HALT).
package proc_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_MVNZ = 3'b101
  } opcode_t;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    HALT = 3'd4
  } state_t;

  // Bus-source codes; general registers use their own index 0..7
  localparam logic [3:0] SEL_G    = 4'd8;
  localparam logic [3:0] SEL_DIN  = 4'd9;
  localparam logic [3:0] SEL_NONE = 4'd15;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // Instruction field positions
  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int RX_HI = 12;
  localparam int RX_LO = 10;
  localparam int RY_HI = 9;
  localparam int RY_LO = 7;

  function automatic logic [1:0] alu_of(input opcode_t op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_control_fsm_reg_decoder.sv
// 3-to-8 one-hot register write-enable decoder.
module reg_decoder_3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  // One enable bit per register, only the indexed one when enabled
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign onehot[i] = en && (idx == 3'(i));
  end

endmodule

// File: rtl/proc_control_fsm.sv
// Control FSM for the 16-bit six-instruction processor: latches IR, steps
// T0..T3 and drives bus select, register/accumulator/ALU enables.
// Optional feature macro: PROC_ILLEGAL_TRAP_EN.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [DW-1:0]   DIN,
  input  logic            GNZ,
  output logic [3:0]      Sel,
  output logic [NREG-1:0] Rin,
  output logic            Ain,
  output logic            Gin,
  output logic [1:0]      AluOp,
  output logic            IRin,
  output logic            Done,
  output logic            Illegal
);

  state_t        state, state_nxt;
  logic [DW-1:0] ir;
  opcode_t       op;
  logic [2:0]    rx, ry;
  logic          rin_en;
  logic          unused_ir_low;

  assign op = opcode_t'(ir[OP_HI:OP_LO]);
  assign rx = ir[RX_HI:RX_LO];
  assign ry = ir[RY_HI:RY_LO];
  assign unused_ir_low = ^ir[RY_LO-1:0];

`ifdef PROC_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_set;
  assign Illegal = illegal_q && !Reset;
`else
  assign Illegal = 1'b0;
`endif

  // Every register write goes to Rx, so one decoder serves all states
  reg_decoder_3to8 u_dec (
    .idx    (rx),
    .en     (rin_en),
    .onehot (Rin)
  );

  // Per-state outputs and next state; everything defaults while Reset is high
  always_comb begin
    Sel       = SEL_NONE;
    rin_en    = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AluOp     = ALU_ADD;
    IRin      = 1'b0;
    Done      = 1'b0;
    state_nxt = state;
`ifdef PROC_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    if (!Reset) begin
      case (state)
        T0: if (Run) begin
          IRin      = 1'b1;
          state_nxt = T1;
        end
        T1: begin
          state_nxt = T0;
          case (op)
            OP_MV: begin
              Sel = {1'b0, ry}; rin_en = 1'b1; Done = 1'b1;
            end
            OP_MVI: begin
              Sel = SEL_DIN; rin_en = 1'b1; Done = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              Sel = {1'b0, rx}; Ain = 1'b1; state_nxt = T2;
            end
            OP_MVNZ: begin
              if (GNZ) begin
                Sel = {1'b0, ry}; rin_en = 1'b1;
              end
              Done = 1'b1;
            end
            default: begin
`ifdef PROC_ILLEGAL_TRAP_EN
              illegal_set = 1'b1;
              state_nxt   = HALT;
`else
              Done = 1'b1;
`endif
            end
          endcase
        end
        T2: begin
          Sel = {1'b0, ry}; Gin = 1'b1; AluOp = alu_of(op); state_nxt = T3;
        end
        T3: begin
          Sel = SEL_G; rin_en = 1'b1; Done = 1'b1; state_nxt = T0;
        end
`ifdef PROC_ILLEGAL_TRAP_EN
        HALT:    state_nxt = HALT;
`endif
        default: state_nxt = T0;
      endcase
    end
  end

  // State, IR and sticky trap flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
`ifdef PROC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (IRin) ir <= DIN;
`ifdef PROC_ILLEGAL_TRAP_EN
      if (illegal_set) illegal_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: each cycle's expected outputs are
// queued when the inputs are driven and compared mid-cycle.
module tb_proc_control_fsm;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic [1:0] aluop;
    logic       irin;
    logic       done;
    logic       illegal;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset, Run, GNZ;
  logic [15:0] DIN;
  logic [3:0]  Sel;
  logic [7:0]  Rin;
  logic        Ain, Gin, IRin, Done, Illegal;
  logic [1:0]  AluOp;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  proc_control_fsm #(.NREG(8), .DW(16)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .GNZ(GNZ),
    .Sel(Sel), .Rin(Rin), .Ain(Ain), .Gin(Gin), .AluOp(AluOp),
    .IRin(IRin), .Done(Done), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  function automatic exp_t mk(input logic [3:0] sel, input logic [7:0] rin,
                              input logic ain, input logic gin, input logic [1:0] aluop,
                              input logic irin, input logic done, input logic ill);
    return '{sel: sel, rin: rin, ain: ain, gin: gin, aluop: aluop,
             irin: irin, done: done, illegal: ill};
  endfunction

  localparam exp_t DEF = '{sel: 4'hF, rin: 8'h00, ain: 1'b0, gin: 1'b0,
                           aluop: 2'b00, irin: 1'b0, done: 1'b0, illegal: 1'b0};
  localparam exp_t LD  = '{sel: 4'hF, rin: 8'h00, ain: 1'b0, gin: 1'b0,
                           aluop: 2'b00, irin: 1'b1, done: 1'b0, illegal: 1'b0};

  // Drive one cycle of inputs, queue its expectation, check at the falling edge
  task automatic cyc(input string tag, input logic rst, input logic run,
                     input logic [15:0] din, input logic gnz, input exp_t e);
    exp_t got, want;
    Reset = rst; Run = run; DIN = din; GNZ = gnz;
    sb.push_back(e);
    @(negedge Clock);
    got  = '{sel: Sel, rin: Rin, ain: Ain, gin: Gin, aluop: AluOp,
             irin: IRin, done: Done, illegal: Illegal};
    want = sb.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; DIN = '0; GNZ = 1'b0;
    @(posedge Clock); #1;
    cyc("reset_run_hi", 1, 1, 16'h2800, 0, DEF);

    // mvi R2, #AA
    cyc("mvi_t0", 0, 1, 16'h2800, 0, LD);
    cyc("mvi_t1", 0, 0, 16'h00AA, 0, mk(4'd9, 8'h04, 0, 0, 2'b00, 0, 1, 0));
    cyc("idle_t0", 0, 0, 16'h0000, 0, DEF);

    // mv R1, R3
    cyc("mv_t0", 0, 1, 16'h0580, 0, LD);
    cyc("mv_t1", 0, 0, 16'h0000, 0, mk(4'd3, 8'h02, 0, 0, 2'b00, 0, 1, 0));

    // sub R3, R4 with Run held (ignored past T0)
    cyc("sub_t0", 0, 1, 16'h6E00, 0, LD);
    cyc("sub_t1", 0, 1, 16'h0000, 0, mk(4'd3, 8'h00, 1, 0, 2'b00, 0, 0, 0));
    cyc("sub_t2", 0, 1, 16'h0000, 0, mk(4'd4, 8'h00, 0, 1, 2'b01, 0, 0, 0));
    cyc("sub_t3", 0, 1, 16'h0000, 0, mk(4'd8, 8'h08, 0, 0, 2'b00, 0, 1, 0));

    // mvnz R5, R6 back-to-back: GNZ=0 then GNZ=1
    cyc("mvnz0_t0", 0, 1, 16'hB700, 0, LD);
    cyc("mvnz0_t1", 0, 1, 16'h0000, 0, mk(4'hF, 8'h00, 0, 0, 2'b00, 0, 1, 0));
    cyc("mvnz1_t0", 0, 1, 16'hB700, 1, LD);
    cyc("mvnz1_t1", 0, 0, 16'h0000, 1, mk(4'd6, 8'h20, 0, 0, 2'b00, 0, 1, 0));

    // add R0, R1 aborted by reset in T2
    cyc("add_t0", 0, 1, 16'h4080, 0, LD);
    cyc("add_t1", 0, 0, 16'h0000, 0, mk(4'd0, 8'h00, 1, 0, 2'b00, 0, 0, 0));
    cyc("add_rst_t2", 1, 0, 16'h0000, 0, DEF);
    cyc("post_rst_t0", 0, 0, 16'h0000, 0, DEF);
    cyc("post_rst_idle", 0, 0, 16'h0000, 0, DEF);
    cyc("post_rst_mv_t0", 0, 1, 16'h0580, 0, LD);
    cyc("post_rst_mv_t1", 0, 0, 16'h0000, 0, mk(4'd3, 8'h02, 0, 0, 2'b00, 0, 1, 0));

    // and R2, R2
    cyc("and_t0", 0, 1, 16'h8900, 0, LD);
    cyc("and_t1", 0, 0, 16'h0000, 0, mk(4'd2, 8'h00, 1, 0, 2'b00, 0, 0, 0));
    cyc("and_t2", 0, 0, 16'h0000, 0, mk(4'd2, 8'h00, 0, 1, 2'b10, 0, 0, 0));
    cyc("and_t3", 0, 0, 16'h0000, 0, mk(4'd8, 8'h04, 0, 0, 2'b00, 0, 1, 0));

    // illegal opcode 111
    cyc("ill_t0", 0, 1, 16'hE000, 0, LD);
`ifdef PROC_ILLEGAL_TRAP_EN
    cyc("ill_t1", 0, 1, 16'h0000, 0, DEF);
    cyc("halt_a", 0, 1, 16'h0580, 0, mk(4'hF, 8'h00, 0, 0, 2'b00, 0, 0, 1));
    cyc("halt_b", 0, 1, 16'h0580, 1, mk(4'hF, 8'h00, 0, 0, 2'b00, 0, 0, 1));
    cyc("halt_rst", 1, 1, 16'h0580, 0, DEF);
`else
    cyc("ill_t1", 0, 0, 16'h0000, 0, mk(4'hF, 8'h00, 0, 0, 2'b00, 0, 1, 0));
    cyc("ill_nop_idle", 0, 0, 16'h0000, 0, DEF);
`endif
    cyc("after_ill_t0", 0, 1, 16'h0580, 0, LD);
    cyc("after_ill_t1", 0, 0, 16'h0000, 0, mk(4'd3, 8'h02, 0, 0, 2'b00, 0, 1, 0));
    // illegal opcode 110 as well
    cyc("ill6_t0", 0, 1, 16'hC000, 0, LD);
`ifdef PROC_ILLEGAL_TRAP_EN
    cyc("ill6_t1", 0, 0, 16'h0000, 0, DEF);
    cyc("ill6_halt", 0, 1, 16'h0000, 0, mk(4'hF, 8'h00, 0, 0, 2'b00, 0, 0, 1));
`else
    cyc("ill6_t1", 0, 0, 16'h0000, 0, mk(4'hF, 8'h00, 0, 0, 2'b00, 0, 1, 0));
    cyc("ill6_idle", 0, 0, 16'h0000, 0, DEF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
